// File: rtl/tile_builder_if.sv
// Pixel-stream and tile-memory bus of the tile builder.
// master is the upstream feeder / memory side, slave is the builder itself.
interface tile_builder_if;
    logic         start;
    logic         pix_valid;
    logic [7:0]   pix_data;
    logic         pix_ready;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         busy;
    logic         done;

    modport master (
        output start, pix_valid, pix_data,
        input  pix_ready, mem_we, mem_addr, mem_wdata, busy, done
    );

    modport slave (
        input  start, pix_valid, pix_data,
        output pix_ready, mem_we, mem_addr, mem_wdata, busy, done
    );
endinterface

// File: rtl/tile_builder.sv
// Builds overlapping 4x4 stride-2 tiles from a raster pixel stream, zero-padding the
// right and bottom edges, and writes each tile to address i*(IMG_W/2)+j.
module tile_builder #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512
) (
    input  logic          clk,
    input  logic          rst,
    tile_builder_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int W2 = IMG_W / 2;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FIN} state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  col_reg, col_next;
    logic [RW-1:0]  row_reg;
    logic [1:0]     slot_reg;
    logic [127:0]   win_reg, win_next;
    logic [23:0]    lb_rd;
    logic [31:0]    new_col;
    logic [1:0]     q_reg [3];
    logic [1:0]     q_cnt_reg;
    logic [15:0]    base_reg, base_now, tile_i, tile_j, drain_addr;
    logic [127:0]   drain_data;
    logic           last_reg;
    logic           pix_ready_reg, mem_we_reg, busy_reg, done_reg;
    logic [15:0]    mem_addr_reg;
    logic [127:0]   mem_wdata_reg;
    logic           accept, col_last, row_last, tile_done, col_extra, row_extra, frame_end;

    // Kind selects the 2x2 shift of the window: bit0 = right pad, bit1 = bottom pad.
    function automatic logic [127:0] shape_tile(input logic [127:0] w, input logic [1:0] kind);
        logic [127:0] t;
        int sr, sc;
        t = '0;
        for (int tr = 0; tr < 4; tr++) begin
            for (int tc = 0; tc < 4; tc++) begin
                sr = tr + (kind[1] ? 2 : 0);
                sc = tc + (kind[0] ? 2 : 0);
                if (sr < 4 && sc < 4)
                    t[(tr*4+tc)*8 +: 8] = w[(sr*4+sc)*8 +: 8];
            end
        end
        return t;
    endfunction

    assign accept    = pix_ready_reg & bus.pix_valid;
    assign col_last  = (col_reg == CW'(IMG_W - 1));
    assign row_last  = (row_reg == RW'(IMG_H - 1));
    assign tile_done = row_reg[0] & (row_reg >= RW'(3)) & col_reg[0] & (col_reg >= CW'(3));
    assign col_extra = tile_done & col_last;
    assign row_extra = tile_done & row_last;
    assign frame_end = row_last & col_last;

    assign tile_i   = 16'(row_reg >> 1) - 16'd1;
    assign tile_j   = 16'(col_reg >> 1) - 16'd1;
    assign base_now = tile_i * 16'(W2) + tile_j;

    assign drain_addr = base_reg + (q_reg[0][0] ? 16'd1 : 16'd0) + (q_reg[0][1] ? 16'(W2) : 16'd0);
    assign drain_data = shape_tile(win_reg, q_reg[0]);

    // Read address runs one step ahead so the registered read lands on the current column.
    always_comb begin
        col_next = col_reg;
        if (state_reg == IDLE && bus.start)
            col_next = '0;
        else if (accept)
            col_next = col_last ? '0 : col_reg + CW'(1);
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_lb
        logic [7:0] mem [IMG_W];
        logic [7:0] rd_q;
        always_ff @(posedge clk) begin
            if (accept && slot_reg == 2'(gi))
                mem[col_reg] <= bus.pix_data;
            rd_q <= mem[col_next];
        end
        assign lb_rd[gi*8 +: 8] = rd_q;
    end

    // Bank slot_reg holds row r-3 (about to be overwritten by row r), the next two hold r-2, r-1.
    always_comb begin
        new_col[31:24] = bus.pix_data;
        case (slot_reg)
            2'd0:    new_col[23:0] = {lb_rd[23:16], lb_rd[15:8],  lb_rd[7:0]};
            2'd1:    new_col[23:0] = {lb_rd[7:0],   lb_rd[23:16], lb_rd[15:8]};
            default: new_col[23:0] = {lb_rd[15:8],  lb_rd[7:0],   lb_rd[23:16]};
        endcase
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_win
        if ((gi % 4) == 3) begin : g_in
            assign win_next[gi*8 +: 8] = new_col[(gi/4)*8 +: 8];
        end else begin : g_sh
            assign win_next[gi*8 +: 8] = win_reg[(gi+1)*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (bus.start) state_next = STREAM;
            STREAM: begin
                if (accept) begin
                    if (col_extra || row_extra)
                        state_next = DRAIN;
                    else if (frame_end)
                        state_next = FIN;
                end
            end
            DRAIN:  if (q_cnt_reg == 2'd0) state_next = last_reg ? FIN : STREAM;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg       <= '0;
            row_reg       <= '0;
            slot_reg      <= '0;
            win_reg       <= '0;
            q_reg[0]      <= '0;
            q_reg[1]      <= '0;
            q_reg[2]      <= '0;
            q_cnt_reg     <= '0;
            base_reg      <= '0;
            last_reg      <= 1'b0;
            pix_ready_reg <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            mem_we_reg    <= 1'b0;
            pix_ready_reg <= (state_next == STREAM);
            busy_reg      <= (state_next == STREAM) || (state_next == DRAIN);
            done_reg      <= (state_next == FIN);
            col_reg       <= col_next;
            if (state_reg == IDLE && bus.start) begin
                row_reg   <= '0;
                slot_reg  <= '0;
                q_cnt_reg <= '0;
                last_reg  <= 1'b0;
            end
            if (accept) begin
                win_reg  <= win_next;
                last_reg <= frame_end;
                if (col_last) begin
                    row_reg  <= row_last ? '0 : row_reg + RW'(1);
                    slot_reg <= (slot_reg == 2'd2) ? 2'd0 : slot_reg + 2'd1;
                end
                if (tile_done) begin
                    mem_we_reg    <= 1'b1;
                    mem_addr_reg  <= base_now;
                    mem_wdata_reg <= win_next;
                    base_reg      <= base_now;
                    if (col_extra && row_extra) begin
                        q_reg[0]  <= 2'd1;
                        q_reg[1]  <= 2'd2;
                        q_reg[2]  <= 2'd3;
                        q_cnt_reg <= 2'd3;
                    end else if (col_extra || row_extra) begin
                        q_reg[0]  <= col_extra ? 2'd1 : 2'd2;
                        q_cnt_reg <= 2'd1;
                    end
                end
            end
            if (state_reg == DRAIN && q_cnt_reg != 2'd0) begin
                mem_we_reg    <= 1'b1;
                mem_addr_reg  <= drain_addr;
                mem_wdata_reg <= drain_data;
                q_reg[0]      <= q_reg[1];
                q_reg[1]      <= q_reg[2];
                q_cnt_reg     <= q_cnt_reg - 2'd1;
            end
        end
    end

    assign bus.pix_ready = pix_ready_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
endmodule

// File: tb/tb_tile_builder.sv
// Directed bench for tile_builder: a 16x16 instance for ramp/random/bubble frames and
// reset, and a 4x4 instance for the hand-computed small-frame case.
module tb_tile_builder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tile_builder_if b4 ();
    tile_builder_if b16 ();

    logic       sel16   = 1'b1;
    logic       start_v = 1'b0;
    logic       valid_v = 1'b0;
    logic [7:0] data_v  = 8'd0;
    logic       ready_mux;

    assign b4.start      = ~sel16 & start_v;
    assign b4.pix_valid  = ~sel16 & valid_v;
    assign b4.pix_data   = data_v;
    assign b16.start     = sel16 & start_v;
    assign b16.pix_valid = sel16 & valid_v;
    assign b16.pix_data  = data_v;
    assign ready_mux     = sel16 ? b16.pix_ready : b4.pix_ready;

    tile_builder #(.IMG_W(4), .IMG_H(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
    tile_builder #(.IMG_W(16), .IMG_H(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic [7:0]   img [256];
    bit           seen [64];
    logic [15:0]  seq [64];

    logic [15:0]  wa16 [1024];
    logic [127:0] wd16 [1024];
    int           wc16 [1024];
    int n16 = 0, ndone16 = 0, done_cyc16 = 0, low16 = 0;
    logic [15:0]  wa4 [16];
    logic [127:0] wd4 [16];
    int n4 = 0, ndone4 = 0, low4 = 0;

    always @(negedge clk) begin
        if (b16.mem_we) begin
            if (n16 < 1024) begin
                wa16[n16] = b16.mem_addr;
                wd16[n16] = b16.mem_wdata;
                wc16[n16] = cyc;
            end
            n16++;
        end
        if (b16.done) begin
            ndone16++;
            done_cyc16 = cyc;
        end
        if (b16.busy && !b16.pix_ready) low16++;
    end

    always @(negedge clk) begin
        if (b4.mem_we) begin
            if (n4 < 16) begin
                wa4[n4] = b4.mem_addr;
                wd4[n4] = b4.mem_wdata;
            end
            n4++;
        end
        if (b4.done) ndone4++;
        if (b4.busy && !b4.pix_ready) low4++;
    end

    // Reference tile straight from the definition: image rows/cols past the edge read 0.
    function automatic logic [127:0] exp_tile(input int w, input int h, input int i, input int j);
        logic [127:0] t;
        int rr, cc;
        t = '0;
        for (int tr = 0; tr < 4; tr++) begin
            for (int tc = 0; tc < 4; tc++) begin
                rr = 2*i + tr;
                cc = 2*j + tc;
                if (rr < h && cc < w) t[(tr*4+tc)*8 +: 8] = img[rr*w + cc];
            end
        end
        return t;
    endfunction

    task automatic stream(input int w, input int npix, input int bubble_pct, input int start_at);
        int   idx;
        int   guard;
        logic acc;
        @(negedge clk);
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        idx   = 0;
        guard = 0;
        while (idx < npix && guard < 20000) begin
            valid_v = (bubble_pct == 0) || ($urandom_range(99) >= bubble_pct);
            data_v  = img[idx];
            start_v = (idx == start_at);
            acc     = valid_v && ready_mux;
            if (acc && idx == 3*w + 3) acc_cyc = cyc;
            @(negedge clk);
            guard++;
            if (acc) idx++;
        end
        valid_v = 1'b0;
        start_v = 1'b0;
        n_checks++;
        if (idx != npix) begin
            n_fail++;
            $display("FAIL stream_timeout accepted %0d required %0d", idx, npix);
        end
    endtask

    task automatic wait_done(input bit s16, input int d0);
        int g;
        g = 0;
        while (((s16 ? ndone16 : ndone4) == d0) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        n_checks++;
        if (g >= 2000) begin
            n_fail++;
            $display("FAIL done_timeout no done within %0d cycles", g);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks += 12;
        if ({b16.pix_ready, b16.mem_we, b16.busy, b16.done} !== 4'b0) begin
            n_fail++; $display("FAIL rst16_flags got %b required 0000", {b16.pix_ready, b16.mem_we, b16.busy, b16.done});
        end
        if (b16.mem_addr !== 16'd0) begin n_fail++; $display("FAIL rst16_addr got %0d required 0", b16.mem_addr); end
        if (b16.mem_wdata !== 128'd0) begin n_fail++; $display("FAIL rst16_wdata got %h required 0", b16.mem_wdata); end
        if ({b4.pix_ready, b4.mem_we, b4.busy, b4.done} !== 4'b0) begin
            n_fail++; $display("FAIL rst4_flags got %b required 0000", {b4.pix_ready, b4.mem_we, b4.busy, b4.done});
        end
        if (b4.mem_addr !== 16'd0) begin n_fail++; $display("FAIL rst4_addr got %0d required 0", b4.mem_addr); end
        if (b4.mem_wdata !== 128'd0) begin n_fail++; $display("FAIL rst4_wdata got %h required 0", b4.mem_wdata); end
        n_fail  += 0;
        n_checks -= 6;
        rst = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) img[r*16 + c] = 8'((r + c) & 255);
        stream(16, 70, 0, -1);
        rst = 1'b1;
        @(negedge clk);
        n_checks += 6;
        if (b16.pix_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got %b required 0", b16.pix_ready); end
        if (b16.mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we got %b required 0", b16.mem_we); end
        if (b16.mem_addr !== 16'd0) begin n_fail++; $display("FAIL midrst_addr got %0d required 0", b16.mem_addr); end
        if (b16.mem_wdata !== 128'd0) begin n_fail++; $display("FAIL midrst_wdata got %h required 0", b16.mem_wdata); end
        if (b16.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b required 0", b16.busy); end
        if (b16.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b required 0", b16.done); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        int base, d0, l0, cnt;
        logic [15:0] a;
        base = n16; d0 = ndone16; l0 = low16;
        stream(16, 256, 0, -1);
        wait_done(1'b1, d0);
        cnt = n16 - base;
        n_checks++;
        if (cnt != 64) begin n_fail++; $display("FAIL ramp_count got %0d required 64", cnt); end
        n_checks += 5;
        if (wa16[base] !== 16'd0) begin n_fail++; $display("FAIL ramp_first_addr got %0d required 0", wa16[base]); end
        if (wd16[base][7:0] !== 8'h00) begin n_fail++; $display("FAIL ramp_first_b0 got %h required 00", wd16[base][7:0]); end
        if (wd16[base][47:40] !== 8'h02) begin n_fail++; $display("FAIL ramp_first_b5 got %h required 02", wd16[base][47:40]); end
        if (wd16[base][127:120] !== 8'h06) begin n_fail++; $display("FAIL ramp_first_b15 got %h required 06", wd16[base][127:120]); end
        if (wc16[base] != acc_cyc + 1) begin n_fail++; $display("FAIL ramp_first_latency got cycle %0d required %0d", wc16[base], acc_cyc + 1); end
        n_checks += 4;
        if (wa16[base+6] !== 16'd6) begin n_fail++; $display("FAIL ramp_row3_order got %0d required 6", wa16[base+6]); end
        if (wa16[base+7] !== 16'd7) begin n_fail++; $display("FAIL ramp_edge_addr got %0d required 7", wa16[base+7]); end
        if ((wd16[base+7] & 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000) !== 128'd0) begin
            n_fail++; $display("FAIL ramp_edge_pad got %h required zero cols 2,3", wd16[base+7]);
        end
        if (wd16[base+7][7:0] !== 8'd14) begin n_fail++; $display("FAIL ramp_edge_b0 got %0d required 14", wd16[base+7][7:0]); end
        n_checks += 6;
        if (wa16[base+60] !== 16'd54 || wa16[base+61] !== 16'd55 || wa16[base+62] !== 16'd62 || wa16[base+63] !== 16'd63) begin
            n_fail++; $display("FAIL ramp_last4 got %0d %0d %0d %0d required 54 55 62 63", wa16[base+60], wa16[base+61], wa16[base+62], wa16[base+63]);
        end
        if (wd16[base+63][127:64] !== 64'd0) begin n_fail++; $display("FAIL ramp_bottom_pad got %h required 0", wd16[base+63][127:64]); end
        if (wd16[base+63][7:0] !== 8'd28) begin n_fail++; $display("FAIL ramp_corner_b0 got %0d required 28", wd16[base+63][7:0]); end
        if (ndone16 - d0 != 1) begin n_fail++; $display("FAIL ramp_done_count got %0d required 1", ndone16 - d0); end
        if (done_cyc16 != wc16[base+63] + 1) begin n_fail++; $display("FAIL ramp_done_timing got %0d required %0d", done_cyc16, wc16[base+63] + 1); end
        if (low16 - l0 != 28) begin n_fail++; $display("FAIL ramp_stall_cycles got %0d required 28", low16 - l0); end
        n_checks++;
        if (b16.busy !== 1'b0) begin n_fail++; $display("FAIL ramp_busy_after got %b required 0", b16.busy); end
        for (int k = 0; k < 64; k++) seen[k] = 1'b0;
        for (int k = 0; k < cnt && k < 64; k++) begin
            a = wa16[base+k];
            n_checks++;
            if (a >= 16'd64 || seen[a[5:0]]) begin
                n_fail++; $display("FAIL ramp_addr_unique write %0d got addr %0d", k, a);
            end else begin
                seen[a[5:0]] = 1'b1;
                n_checks++;
                if (wd16[base+k] !== exp_tile(16, 16, int'(a) / 8, int'(a) % 8)) begin
                    n_fail++; $display("FAIL ramp_tile addr %0d got %h required %h", a, wd16[base+k], exp_tile(16, 16, int'(a) / 8, int'(a) % 8));
                end
            end
        end
    endtask

    task automatic test_coverage();
        int base, d0, l0, cnt;
        logic [15:0] a;
        for (int k = 0; k < 256; k++) img[k] = 8'($urandom_range(255));
        base = n16; d0 = ndone16; l0 = low16;
        stream(16, 256, 0, -1);
        wait_done(1'b1, d0);
        cnt = n16 - base;
        n_checks += 3;
        if (cnt != 64) begin n_fail++; $display("FAIL cov_count got %0d required 64", cnt); end
        if (ndone16 - d0 != 1) begin n_fail++; $display("FAIL cov_done_count got %0d required 1", ndone16 - d0); end
        if (low16 - l0 != 28) begin n_fail++; $display("FAIL cov_stall_cycles got %0d required 28", low16 - l0); end
        for (int k = 0; k < 64; k++) seen[k] = 1'b0;
        for (int k = 0; k < cnt && k < 64; k++) begin
            a = wa16[base+k];
            seq[k] = a;
            n_checks++;
            if (a >= 16'd64 || seen[a[5:0]]) begin
                n_fail++; $display("FAIL cov_addr_unique write %0d got addr %0d", k, a);
            end else begin
                seen[a[5:0]] = 1'b1;
                n_checks++;
                if (wd16[base+k] !== exp_tile(16, 16, int'(a) / 8, int'(a) % 8)) begin
                    n_fail++; $display("FAIL cov_tile addr %0d got %h required %h", a, wd16[base+k], exp_tile(16, 16, int'(a) / 8, int'(a) % 8));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int base, d0, l0, cnt;
        logic [15:0] a;
        base = n16; d0 = ndone16; l0 = low16;
        stream(16, 256, 30, -1);
        wait_done(1'b1, d0);
        cnt = n16 - base;
        n_checks += 3;
        if (cnt != 64) begin n_fail++; $display("FAIL bp_count got %0d required 64", cnt); end
        if (ndone16 - d0 != 1) begin n_fail++; $display("FAIL bp_done_count got %0d required 1", ndone16 - d0); end
        if (low16 - l0 != 28) begin n_fail++; $display("FAIL bp_stall_cycles got %0d required 28", low16 - l0); end
        for (int k = 0; k < cnt && k < 64; k++) begin
            a = wa16[base+k];
            n_checks += 2;
            if (a !== seq[k]) begin n_fail++; $display("FAIL bp_sequence write %0d got addr %0d required %0d", k, a, seq[k]); end
            if (wd16[base+k] !== exp_tile(16, 16, int'(a) / 8, int'(a) % 8)) begin
                n_fail++; $display("FAIL bp_tile addr %0d got %h required %h", a, wd16[base+k], exp_tile(16, 16, int'(a) / 8, int'(a) % 8));
            end
        end
    endtask

    task automatic test_small();
        int base, d0, l0, cnt;
        @(negedge clk);
        sel16 = 1'b0;
        for (int k = 0; k < 16; k++) img[k] = 8'(k);
        base = n4; d0 = ndone4; l0 = low4;
        stream(4, 16, 0, 6);
        wait_done(1'b0, d0);
        cnt = n4 - base;
        n_checks += 11;
        if (cnt != 4) begin n_fail++; $display("FAIL small_count got %0d required 4", cnt); end
        if (wa4[base] !== 16'd0 || wa4[base+1] !== 16'd1 || wa4[base+2] !== 16'd2 || wa4[base+3] !== 16'd3) begin
            n_fail++; $display("FAIL small_order got %0d %0d %0d %0d required 0 1 2 3", wa4[base], wa4[base+1], wa4[base+2], wa4[base+3]);
        end
        if (wd4[base] !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin
            n_fail++; $display("FAIL small_tile0 got %h", wd4[base]);
        end
        if (wd4[base+1] !== 128'h00000F0E_00000B0A_00000706_00000302) begin
            n_fail++; $display("FAIL small_tile1 got %h required 00000f0e00000b0a0000070600000302", wd4[base+1]);
        end
        if (wd4[base+2] !== 128'h00000000_00000000_0F0E0D0C_0B0A0908) begin
            n_fail++; $display("FAIL small_tile2 got %h required 00000000000000000f0e0d0c0b0a0908", wd4[base+2]);
        end
        if (wd4[base+3] !== 128'h00000000_00000000_00000F0E_00000B0A) begin
            n_fail++; $display("FAIL small_tile3 got %h required 000000000000000000000f0e00000b0a", wd4[base+3]);
        end
        if (ndone4 - d0 != 1) begin n_fail++; $display("FAIL small_done_count got %0d required 1", ndone4 - d0); end
        if (low4 - l0 != 4) begin n_fail++; $display("FAIL small_stall_cycles got %0d required 4", low4 - l0); end
        if (wd4[base] !== exp_tile(4, 4, 0, 0)) begin n_fail++; $display("FAIL small_model0 got %h", wd4[base]); end
        repeat (10) @(negedge clk);
        if (n4 - base != 4) begin n_fail++; $display("FAIL small_no_restart got %0d writes required 4", n4 - base); end
        if (b4.busy !== 1'b0) begin n_fail++; $display("FAIL small_busy_after got %b required 0", b4.busy); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_coverage();
        test_backpressure();
        test_small();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
